// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment display readback path.
// Segment patterns and digit selects are active-low, exactly as seen on the display bus.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [2:0] DSEL_UNITS    = 3'b110;
  localparam logic [2:0] DSEL_TENS     = 3'b101;
  localparam logic [2:0] DSEL_HUNDREDS = 3'b011;
  localparam logic [2:0] DSEL_IDLE     = 3'b111;

  typedef enum logic [1:0] {WAIT_U, WAIT_D, WAIT_C} frame_state_t;

  // Three BCD digits to binary; every digit is 0..9 so 10 bits never overflow.
  function automatic logic [9:0] bcd3_to_bin(input logic [3:0] c,
                                             input logic [3:0] d,
                                             input logic [3:0] u);
    return 10'(c) * 10'd100 + 10'(d) * 10'd10 + 10'(u);
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of an active-low 7-segment pattern to a BCD digit.
// Anything that is not one of the ten digit glyphs (blank included) is flagged invalid.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       valid
);

  // NOTE: both outputs get a default before the case so no latch is inferred.
  always_comb begin
    digit = 4'd0;
    valid = 1'b1;
    case (seg)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_mux_readback.sv
// Snoops a multiplexed 3-digit 7-segment bus, filters refresh glitches and
// rebuilds the displayed value from a units -> tens -> hundreds frame.
module seg7_mux_readback
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 150000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic [2:0] digit_sel_in,
  output logic [9:0] value,
  output logic       value_valid,
  output logic       seg_err,
  output logic       frame_err,
  output logic       stale
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [6:0]   seg_s1, seg_s2, seg_prev;
  logic [2:0]   sel_s1, sel_s2, sel_prev;
  logic [SW-1:0] stab_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [3:0]   digit_u, digit_d;
  frame_state_t state;

  logic       sample_same, sel_valid, cap, publish;
  logic [3:0] pat_digit;
  logic       pat_valid;

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s1   <= SEG_BLANK;
      seg_s2   <= SEG_BLANK;
      seg_prev <= SEG_BLANK;
      sel_s1   <= DSEL_IDLE;
      sel_s2   <= DSEL_IDLE;
      sel_prev <= DSEL_IDLE;
    end else begin
      seg_s1   <= seg_in;
      seg_s2   <= seg_s1;
      seg_prev <= seg_s2;
      sel_s1   <= digit_sel_in;
      sel_s2   <= sel_s1;
      sel_prev <= sel_s2;
    end
  end

  assign sample_same = (seg_s2 == seg_prev) && (sel_s2 == sel_prev);
  assign sel_valid   = sel_s2 inside {DSEL_UNITS, DSEL_TENS, DSEL_HUNDREDS};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stab_cnt <= '0;
    else if (!sample_same)
      stab_cnt <= SW'(1);
    else if (stab_cnt != SW'(STABLE_CYCLES))
      stab_cnt <= stab_cnt + 1'b1;
  end

  // Strobe in the cycle whose edge moves the counter onto STABLE_CYCLES.
  assign cap = sample_same && (stab_cnt == SW'(STABLE_CYCLES - 1)) && sel_valid;

  seg7_to_bcd u_dec (
    .seg   (seg_s2),
    .digit (pat_digit),
    .valid (pat_valid)
  );

  assign publish = cap && pat_valid && (state == WAIT_C) && (sel_s2 == DSEL_HUNDREDS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_U;
      digit_u     <= 4'd0;
      digit_d     <= 4'd0;
      value       <= 10'd0;
      value_valid <= 1'b0;
      seg_err     <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      seg_err     <= 1'b0;
      frame_err   <= 1'b0;
      if (cap) begin
        if (!pat_valid) begin
          seg_err <= 1'b1;
          state   <= WAIT_U;
        end else begin
          case (state)
            WAIT_U: begin
              // Tens/hundreds seen here just mean we joined mid-frame.
              if (sel_s2 == DSEL_UNITS) begin
                digit_u <= pat_digit;
                state   <= WAIT_D;
              end
            end
            WAIT_D: begin
              case (sel_s2)
                DSEL_UNITS: digit_u <= pat_digit;
                DSEL_TENS: begin
                  digit_d <= pat_digit;
                  state   <= WAIT_C;
                end
                default: begin
                  frame_err <= 1'b1;
                  state     <= WAIT_U;
                end
              endcase
            end
            WAIT_C: begin
              case (sel_s2)
                DSEL_HUNDREDS: begin
                  value       <= bcd3_to_bin(pat_digit, digit_d, digit_u);
                  value_valid <= 1'b1;
                  state       <= WAIT_U;
                end
                DSEL_UNITS: begin
                  frame_err <= 1'b1;
                  digit_u   <= pat_digit;
                  state     <= WAIT_D;
                end
                default: begin
                  frame_err <= 1'b1;
                  state     <= WAIT_U;
                end
              endcase
            end
            default: state <= WAIT_U;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tmo_cnt <= '0;
    else if (publish)
      tmo_cnt <= '0;
    else if (tmo_cnt != TW'(TIMEOUT_CYCLES))
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Clearing on publish makes stale fall in the same cycle value_valid rises.
  assign stale = (tmo_cnt == TW'(TIMEOUT_CYCLES));

endmodule

// File: tb/tb_seg7_mux_readback.sv
// Scoreboard bench for seg7_mux_readback: expected output pulses are queued as
// the bus is driven and matched against DUT pulses sampled on the falling edge.
module tb_seg7_mux_readback;
  import seg7_pkg::*;

  localparam int STABLE = 4;
  localparam int TMO    = 300;
  localparam int HOLD   = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg_in = SEG_BLANK;
  logic [2:0] digit_sel_in = DSEL_IDLE;
  logic [9:0] value;
  logic       value_valid, seg_err, frame_err, stale;

  seg7_mux_readback #(
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .seg_in       (seg_in),
    .digit_sel_in (digit_sel_in),
    .value        (value),
    .value_valid  (value_valid),
    .seg_err      (seg_err),
    .frame_err    (frame_err),
    .stale        (stale)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_VALID = 0, EV_SEG = 1, EV_FRAME = 2} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       val;
  } ev_t;

  ev_t        exp_q[$];
  int         exp_val = 0;
  int         n_vec = 0;
  int         n_err = 0;
  logic [6:0] lut [10];

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Every output pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    ev_t e;
    int  k;
    if (!rst && (value_valid || seg_err || frame_err)) begin
      k = value_valid ? EV_VALID : (seg_err ? EV_SEG : EV_FRAME);
      check("pulse_exclusive", int'(value_valid) + int'(seg_err) + int'(frame_err), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_event", k, -1);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", k, int'(e.kind));
        check("event_value", int'(value), e.val);
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic show(input logic [2:0] sel, input logic [6:0] pat, input int n = HOLD);
    digit_sel_in = sel;
    seg_in       = pat;
    hold(n);
  endtask

  task automatic frame(input int v);
    show(DSEL_UNITS, lut[v % 10]);
    show(DSEL_TENS, lut[(v / 10) % 10]);
    exp_val = v;
    exp_q.push_back('{EV_VALID, v});
    show(DSEL_HUNDREDS, lut[v / 100]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_value"}, int'(value), 0);
    check({tag, "_value_valid"}, int'(value_valid), 0);
    check({tag, "_seg_err"}, int'(seg_err), 0);
    check({tag, "_frame_err"}, int'(frame_err), 0);
    check({tag, "_stale"}, int'(stale), 0);
  endtask

  initial begin
    int   found;
    int   n;
    logic prev_stale;
    lut = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7, SEG_8, SEG_9};

    hold(3);
    check_all_zero("reset");
    rst = 1'b0;
    hold(5);

    // Basic frame and repeated frames: one pulse per frame.
    frame(123);
    frame(123);
    frame(123);
    check("value_123", int'(value), 123);
    check("stale_idle_ok", int'(stale), 0);

    // Value range: mid, zero, maximum.
    frame(255);
    frame(0);
    frame(999);
    check("value_999", int'(value), 999);

    // Short glitch to tens inside the units slot must not capture.
    show(DSEL_UNITS, lut[7], 10);
    show(DSEL_TENS, 7'($urandom_range(0, 127)), 2);
    show(DSEL_UNITS, lut[7], 30);
    show(DSEL_TENS, lut[8]);
    exp_val = 387;
    exp_q.push_back('{EV_VALID, 387});
    show(DSEL_HUNDREDS, lut[3]);
    check("value_glitch_frame", int'(value), 387);

    // Blank tens digit: seg_err, no publish, value held.
    show(DSEL_UNITS, lut[1]);
    exp_q.push_back('{EV_SEG, exp_val});
    show(DSEL_TENS, SEG_BLANK);
    show(DSEL_HUNDREDS, lut[2]);
    check("value_after_seg_err", int'(value), 387);
    frame(456);

    // Units then hundreds: frame_err, no publish.
    show(DSEL_UNITS, lut[4]);
    exp_q.push_back('{EV_FRAME, exp_val});
    show(DSEL_HUNDREDS, lut[6]);
    show(DSEL_IDLE, SEG_BLANK, 10);
    check("value_after_frame_err", int'(value), 456);

    // Reset after the tens capture discards the partial frame.
    show(DSEL_UNITS, lut[1]);
    show(DSEL_TENS, lut[2]);
    rst          = 1'b1;
    digit_sel_in = DSEL_IDLE;
    seg_in       = SEG_BLANK;
    hold(2);
    check_all_zero("midframe_rst");
    exp_val = 0;
    rst     = 1'b0;
    hold(3);
    frame(789);
    check("value_after_rst", int'(value), 789);

    // Staleness: rises TMO cycles after value_valid, drops with the next publish.
    show(DSEL_UNITS, lut[5]);
    show(DSEL_TENS, lut[4]);
    exp_val = 345;
    exp_q.push_back('{EV_VALID, 345});
    digit_sel_in = DSEL_HUNDREDS;
    seg_in       = lut[3];
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      @(negedge clk);
      if (value_valid) found = 1;
    end
    check("s6_publish_seen", found, 1);
    digit_sel_in = DSEL_IDLE;
    seg_in       = SEG_BLANK;
    n = 0;
    while (!stale && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("stale_delay", n, TMO);
    check("stale_level", int'(stale), 1);
    hold(20);
    show(DSEL_UNITS, lut[8]);
    show(DSEL_TENS, lut[7]);
    exp_val = 678;
    exp_q.push_back('{EV_VALID, 678});
    digit_sel_in = DSEL_HUNDREDS;
    seg_in       = lut[6];
    found      = 0;
    prev_stale = stale;
    for (int i = 0; i < 60 && found == 0; i++) begin
      @(negedge clk);
      if (value_valid) found = 1;
      else prev_stale = stale;
    end
    check("s6b_publish_seen", found, 1);
    check("stale_before_publish", int'(prev_stale), 1);
    check("stale_in_valid_cycle", int'(stale), 0);

    show(DSEL_IDLE, SEG_BLANK, 20);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
